// File: rtl/vx_index_decoder_pkg.sv
// Shared types and width helpers for the index decoder slice.
// Widths follow LOG2UP(N): at least one index bit, even when N is 1.
package vx_index_decoder_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int log2Up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One extra bit so a fully populated mask (count == N) still fits.
  function automatic int countWidth(input int n);
    return log2Up(n) + 1;
  endfunction

endpackage

// File: rtl/vx_onehot_decode.sv
// Combinational index-to-bit decoder.
// Indices at or beyond N decode to an all-zero mask and report in_range_o=0.
module vx_onehot_decode
  import vx_index_decoder_pkg::*;
#(
  parameter int N       = 4,
  parameter bit REVERSE = 1'b0,
  localparam int LN     = log2Up(N)
) (
  input  logic [LN-1:0] index_i,
  output logic [N-1:0]  onehot_o,
  output logic          in_range_o
);

  // Bit b is hit by exactly one in-range index, so out-of-range codes match nothing.
  always_comb begin
    onehot_o = '0;
    for (int b = 0; b < N; b++) begin
      onehot_o[b] = (index_i == LN'(REVERSE ? (N - 1 - b) : b));
    end
  end

  assign in_range_o = ({1'b0, index_i} < (LN + 1)'(N));

endmodule

// File: rtl/vx_index_decoder.sv
// Rebuilds an N-bit mask from a stream of encoded indices; emits it when the last beat lands.
// Optional err output for duplicate/out-of-range beats: define VX_INDEX_DECODER_ERR_EN.
module vx_index_decoder
  import vx_index_decoder_pkg::*;
#(
  parameter int N       = 4,
  parameter bit REVERSE = 1'b0,
  localparam int LN     = log2Up(N),
  localparam int CW     = countWidth(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [LN-1:0] in_index,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_mask,
  output logic [CW-1:0] out_count,
  input  logic          out_ready
`ifdef VX_INDEX_DECODER_ERR_EN
  ,
  output logic          err
`endif
);

  state_t        state_q, state_d;
  logic [N-1:0]  mask_q, mask_d;
  logic [CW-1:0] count_q, count_d;

  logic [N-1:0]  onehot;
  logic          inRange;
  logic [N-1:0]  beatBits;
  logic          beatIsNew;
  logic          inFire;
  logic          outFire;

  vx_onehot_decode #(
    .N       (N),
    .REVERSE (REVERSE)
  ) uDecode (
    .index_i    (in_index),
    .onehot_o   (onehot),
    .in_range_o (inRange)
  );

  assign beatBits  = inRange ? onehot : '0;
  assign beatIsNew = |(beatBits & ~mask_q);

  // In HOLD the input only advances when the held mask leaves in the same cycle.
  assign out_valid = (state_q == HOLD);
  assign in_ready  = (state_q == ACCUM) || out_ready;
  assign inFire    = in_valid && in_ready;
  assign outFire   = out_valid && out_ready;
  assign out_mask  = mask_q;
  assign out_count = count_q;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    case (state_q)
      ACCUM: begin
        if (inFire) begin
          mask_d  = mask_q | beatBits;
          count_d = count_q + CW'(beatIsNew);
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (outFire) begin
          if (inFire) begin
            mask_d  = beatBits;
            count_d = CW'(|beatBits);
            state_d = in_last ? HOLD : ACCUM;
          end else begin
            mask_d  = '0;
            count_d = '0;
            state_d = ACCUM;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ACCUM;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

`ifdef VX_INDEX_DECODER_ERR_EN
  logic err_q, err_d;
  logic beatBad;

  // A beat arriving alongside an out fire starts a fresh mask, so it cannot be a duplicate.
  assign beatBad = inFire && (!inRange || ((state_q == ACCUM) && (|(onehot & mask_q))));

  always_comb begin
    err_d = err_q;
    if (state_q == ACCUM) begin
      err_d = err_q | beatBad;
    end else if (outFire) begin
      err_d = beatBad;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_vx_index_decoder.sv
// Bench for vx_index_decoder: N=8, N=8 reversed and N=6 instances fed the same beats.
// Fixed vectors and reset sequences first, then random traffic against a queue-based model.
module tb_vx_index_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inValid = 1'b0;
  logic [2:0] inIndex = '0;
  logic       inLast = 1'b0;
  logic       outReady = 1'b0;

  logic       inReadyA, inReadyR, inReadyS;
  logic       outValidA, outValidR, outValidS;
  logic [7:0] outMaskA, outMaskR;
  logic [5:0] outMaskS;
  logic [3:0] outCountA, outCountR, outCountS;
`ifdef VX_INDEX_DECODER_ERR_EN
  logic       errA, errR, errS;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vx_index_decoder #(.N(8), .REVERSE(1'b0)) dutA (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_index(inIndex), .in_last(inLast),
    .in_ready(inReadyA), .out_valid(outValidA), .out_mask(outMaskA), .out_count(outCountA),
    .out_ready(outReady)
`ifdef VX_INDEX_DECODER_ERR_EN
    , .err(errA)
`endif
  );

  vx_index_decoder #(.N(8), .REVERSE(1'b1)) dutR (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_index(inIndex), .in_last(inLast),
    .in_ready(inReadyR), .out_valid(outValidR), .out_mask(outMaskR), .out_count(outCountR),
    .out_ready(outReady)
`ifdef VX_INDEX_DECODER_ERR_EN
    , .err(errR)
`endif
  );

  vx_index_decoder #(.N(6), .REVERSE(1'b0)) dutS (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_index(inIndex), .in_last(inLast),
    .in_ready(inReadyS), .out_valid(outValidS), .out_mask(outMaskS), .out_count(outCountS),
    .out_ready(outReady)
`ifdef VX_INDEX_DECODER_ERR_EN
    , .err(errS)
`endif
  );

  typedef struct {
    logic       v;
    logic [2:0] idx;
    logic       last;
    logic       ordy;
    logic       expV;
    logic       expRdy;
    logic [7:0] m8;
    logic [3:0] c8;
    logic [7:0] mR;
    logic [5:0] m6;
    logic [3:0] c6;
    logic       errA;
    logic       errS;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl[NVEC];

  function automatic vec_t mk(input logic v, input int idx, input logic last, input logic ordy,
                              input logic expV, input logic expRdy, input int m8, input int c8,
                              input int mR, input int m6, input int c6,
                              input logic eA, input logic eS);
    vec_t r;
    r.v = v; r.idx = 3'(idx); r.last = last; r.ordy = ordy;
    r.expV = expV; r.expRdy = expRdy;
    r.m8 = 8'(m8); r.c8 = 4'(c8); r.mR = 8'(mR); r.m6 = 6'(m6); r.c6 = 4'(c6);
    r.errA = eA; r.errS = eS;
    return r;
  endfunction

  // Reference: a mask is the set of in-range indices it was built from.
  function automatic int modelMask(input int n, input bit rev, input int q[$]);
    int m = 0;
    foreach (q[i]) begin
      if (q[i] < n) m = m | (1 << (rev ? (n - 1 - q[i]) : q[i]));
    end
    return m;
  endfunction

  function automatic bit modelErr(input int n, input int q[$]);
    foreach (q[i]) begin
      if (q[i] >= n) return 1'b1;
      for (int j = 0; j < i; j++) begin
        if (q[j] == q[i]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] idx, input logic last,
                               input logic ordy);
    inValid  = v;
    inIndex  = idx;
    inLast   = last;
    outReady = ordy;
    step();
  endtask

  bit   holdValid;
  int   heldList[$];
  int   accList[$];
  logic mReady, mOutFire, mInFire, doReset;

  initial begin
    tbl[0]  = mk(1, 1, 0, 1, 0, 1, 8'h00, 0, 8'h00, 6'h00, 0, 0, 0);
    tbl[1]  = mk(1, 4, 0, 1, 0, 1, 8'h00, 0, 8'h00, 6'h00, 0, 0, 0);
    tbl[2]  = mk(1, 6, 1, 1, 1, 1, 8'h52, 3, 8'h4A, 6'h12, 2, 0, 1);
    tbl[3]  = mk(0, 0, 0, 1, 0, 1, 8'h00, 0, 8'h00, 6'h00, 0, 0, 0);
    tbl[4]  = mk(1, 0, 1, 1, 1, 1, 8'h01, 1, 8'h80, 6'h01, 1, 0, 0);
    tbl[5]  = mk(1, 3, 0, 1, 0, 1, 8'h00, 0, 8'h00, 6'h00, 0, 0, 0);
    tbl[6]  = mk(1, 3, 1, 1, 1, 1, 8'h08, 1, 8'h10, 6'h08, 1, 1, 1);
    tbl[7]  = mk(0, 0, 0, 1, 0, 1, 8'h00, 0, 8'h00, 6'h00, 0, 0, 0);
    tbl[8]  = mk(1, 7, 1, 1, 1, 1, 8'h80, 1, 8'h01, 6'h00, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 1, 0, 1, 8'h00, 0, 8'h00, 6'h00, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 8'h00, 0, 8'h00, 6'h00, 0, 0, 0);
    tbl[11] = mk(1, 5, 1, 0, 1, 0, 8'h21, 2, 8'h84, 6'h21, 2, 0, 0);
    for (int i = 12; i < 16; i++) begin
      tbl[i] = mk(1, 2, 1, 0, 1, 0, 8'h21, 2, 8'h84, 6'h21, 2, 0, 0);
    end
    tbl[16] = mk(1, 2, 1, 1, 1, 1, 8'h04, 1, 8'h20, 6'h04, 1, 0, 0);
    tbl[17] = mk(0, 0, 0, 1, 0, 1, 8'h00, 0, 8'h00, 6'h00, 0, 0, 0);

    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    checkOutput("reset out_valid", int'(outValidA), 0);
    checkOutput("reset in_ready", int'(inReadyA), 1);
`ifdef VX_INDEX_DECODER_ERR_EN
    checkOutput("reset err", int'(errA), 0);
`endif

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(tbl[i].v, tbl[i].idx, tbl[i].last, tbl[i].ordy);
      checkOutput($sformatf("vec%0d out_valid", i), int'(outValidA), int'(tbl[i].expV));
      checkOutput($sformatf("vec%0d in_ready", i), int'(inReadyA), int'(tbl[i].expRdy));
      if (tbl[i].expV) begin
        checkOutput($sformatf("vec%0d mask8", i), int'(outMaskA), int'(tbl[i].m8));
        checkOutput($sformatf("vec%0d count8", i), int'(outCountA), int'(tbl[i].c8));
        checkOutput($sformatf("vec%0d maskRev", i), int'(outMaskR), int'(tbl[i].mR));
        checkOutput($sformatf("vec%0d countRev", i), int'(outCountR), int'(tbl[i].c8));
        checkOutput($sformatf("vec%0d mask6", i), int'(outMaskS), int'(tbl[i].m6));
        checkOutput($sformatf("vec%0d count6", i), int'(outCountS), int'(tbl[i].c6));
      end
`ifdef VX_INDEX_DECODER_ERR_EN
      checkOutput($sformatf("vec%0d err8", i), int'(errA), int'(tbl[i].errA));
      checkOutput($sformatf("vec%0d err6", i), int'(errS), int'(tbl[i].errS));
`endif
    end

    // Reset in the middle of accumulation discards the partial mask.
    applyStimulus(1, 3'd0, 0, 1);
    applyStimulus(1, 3'd5, 0, 1);
    reset = 1'b0;
    applyStimulus(0, 3'd0, 0, 1);
    reset = 1'b1;
    checkOutput("midmask reset out_valid", int'(outValidA), 0);
    checkOutput("midmask reset in_ready", int'(inReadyA), 1);
    applyStimulus(1, 3'd7, 1, 1);
    checkOutput("after reset out_valid", int'(outValidA), 1);
    checkOutput("after reset mask8", int'(outMaskA), 8'h80);
    checkOutput("after reset count8", int'(outCountA), 1);

    // Reset while a mask is held drops out_valid.
    outReady = 1'b0;
    reset = 1'b0;
    applyStimulus(0, 3'd0, 0, 0);
    reset = 1'b1;
    checkOutput("hold reset out_valid", int'(outValidA), 0);
    checkOutput("hold reset in_ready", int'(inReadyA), 1);

    holdValid = 1'b0;
    heldList.delete();
    accList.delete();
    for (int cyc = 0; cyc < 500; cyc++) begin
      reset    = 1'b1;
      inValid  = ($urandom_range(0, 3) != 0);
      inIndex  = 3'($urandom_range(0, 7));
      inLast   = ($urandom_range(0, 2) == 0);
      outReady = ($urandom_range(0, 3) != 0);
      doReset  = ($urandom_range(0, 99) == 0);
      mReady   = !holdValid || outReady;
      mOutFire = holdValid && outReady;
      mInFire  = inValid && mReady;
      if (doReset) reset = 1'b0;
      step();
      if (doReset) begin
        holdValid = 1'b0;
        heldList.delete();
        accList.delete();
      end else begin
        if (mOutFire) begin
          holdValid = 1'b0;
          heldList.delete();
        end
        if (mInFire) begin
          accList.push_back(int'(inIndex));
          if (inLast) begin
            heldList = accList;
            accList.delete();
            holdValid = 1'b1;
          end
        end
      end
      reset = 1'b1;
      #1;
      checkOutput("rand out_valid8", int'(outValidA), int'(holdValid));
      checkOutput("rand out_validRev", int'(outValidR), int'(holdValid));
      checkOutput("rand out_valid6", int'(outValidS), int'(holdValid));
      checkOutput("rand in_ready", int'(inReadyA), int'(!holdValid || outReady));
      if (holdValid) begin
        checkOutput("rand mask8", int'(outMaskA), modelMask(8, 1'b0, heldList));
        checkOutput("rand count8", int'(outCountA), $countones(modelMask(8, 1'b0, heldList)));
        checkOutput("rand maskRev", int'(outMaskR), modelMask(8, 1'b1, heldList));
        checkOutput("rand mask6", int'(outMaskS), modelMask(6, 1'b0, heldList));
        checkOutput("rand count6", int'(outCountS), $countones(modelMask(6, 1'b0, heldList)));
      end
`ifdef VX_INDEX_DECODER_ERR_EN
      checkOutput("rand err8", int'(errA),
                  int'(holdValid ? modelErr(8, heldList) : modelErr(8, accList)));
      checkOutput("rand err6", int'(errS),
                  int'(holdValid ? modelErr(6, heldList) : modelErr(6, accList)));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
